// File: rtl/seg7_pkg.sv
// Shared types and constants for the 4-digit 7-segment scan driver.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

  typedef logic [1:0] digit_idx_t;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;
  localparam seg_t SEG_DASH  = 7'h3F;
  localparam int   N_DIGITS  = 4;

  function automatic logic has_bad_digit(input logic [15:0] w);
    logic b;
    b = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (w[i*4 +: 4] > 4'd9) b = 1'b1;
    end
    return b;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Nibble to active-low 7-segment pattern; non-BCD nibbles show a dash.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  output seg_t       o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    unique case (i_nib)
      4'd0:    o_seg = 7'b1000000;
      4'd1:    o_seg = 7'b1111001;
      4'd2:    o_seg = 7'b0100100;
      4'd3:    o_seg = 7'b0110000;
      4'd4:    o_seg = 7'b0011001;
      4'd5:    o_seg = 7'b0010010;
      4'd6:    o_seg = 7'b0000010;
      4'd7:    o_seg = 7'b1111000;
      4'd8:    o_seg = 7'b0000000;
      4'd9:    o_seg = 7'b0010000;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit common-anode driver for two packed BCD pairs,
// with frame-aligned (tear-free) updates and per-pair leading-zero blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] bcd_in,
  input  logic        bcd_valid,
  input  logic        blank_lz,
  input  logic [3:0]  dp_in,
  output seg_t        seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        bcd_err
);

  if (REFRESH_DIV < 2) begin : g_bad_div
    $error("REFRESH_DIV must be >= 2");
  end

  localparam int PW = (REFRESH_DIV < 2) ? 1 : $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);
  localparam digit_idx_t    IDX_MAX = digit_idx_t'(N_DIGITS - 1);

  logic [PW-1:0] r_pre;
  digit_idx_t    r_idx;
  logic [15:0]   r_pend;
  logic [15:0]   r_disp;
  logic [3:0]    r_pend_dp;
  logic [3:0]    r_disp_dp;
  logic          r_pend_flag;

  logic       w_wrap;
  logic       w_frame;
  logic [3:0] w_nib;
  seg_t       w_dec;
  logic       w_blank;

  assign w_wrap  = (r_pre == PRE_MAX);
  assign w_frame = w_wrap && (r_idx == IDX_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
      r_idx <= '0;
    end else if (w_wrap) begin
      r_pre <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  // A load landing on the boundary bypasses the pending stage entirely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend      <= '0;
      r_pend_dp   <= '0;
      r_pend_flag <= 1'b0;
      r_disp      <= '0;
      r_disp_dp   <= '0;
      bcd_err     <= 1'b0;
    end else if (w_frame && bcd_valid) begin
      r_disp      <= bcd_in;
      r_disp_dp   <= dp_in;
      bcd_err     <= has_bad_digit(bcd_in);
      r_pend_flag <= 1'b0;
    end else if (w_frame && r_pend_flag) begin
      r_disp      <= r_pend;
      r_disp_dp   <= r_pend_dp;
      bcd_err     <= has_bad_digit(r_pend);
      r_pend_flag <= 1'b0;
    end else if (bcd_valid) begin
      r_pend      <= bcd_in;
      r_pend_dp   <= dp_in;
      r_pend_flag <= 1'b1;
    end
  end

  assign w_nib = r_disp[{r_idx, 2'b00} +: 4];

  seg7_decode u_dec (
    .i_nib (w_nib),
    .o_seg (w_dec)
  );

  // Digits 1 and 3 are the tens of each pair.
  assign w_blank = blank_lz && r_idx[0] && (w_nib == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= ~(4'b0001 << r_idx);
      seg <= w_blank ? SEG_BLANK : w_dec;
      dp  <= ~r_disp_dp[r_idx];
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver at REFRESH_DIV=4: the stimulus
// queues one expected entry per digit slot, the monitor checks each slot.
module tb_seg7_scan_driver;

  logic        clk;
  logic        rst_n;
  logic [15:0] bcd_in;
  logic        bcd_valid;
  logic        blank_lz;
  logic [3:0]  dp_in;
  logic [6:0]  o_seg;
  logic        o_dp;
  logic [3:0]  o_an;
  logic        o_err;

  int vectors;
  int miscompares;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       err;
  } exp_t;

  exp_t q[$];

  seg7_scan_driver #(.REFRESH_DIV(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bcd_in    (bcd_in),
    .bcd_valid (bcd_valid),
    .blank_lz  (blank_lz),
    .dp_in     (dp_in),
    .seg       (o_seg),
    .dp        (o_dp),
    .an        (o_an),
    .bcd_err   (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] pat(input logic [3:0] n);
    case (n)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  task automatic push_frame(input logic [15:0] w, input logic [3:0] dpv,
                            input logic blz, input logic err);
    logic [3:0] an_tab [4];
    exp_t       e;
    logic [3:0] nib;
    an_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    for (int d = 0; d < 4; d++) begin
      nib   = w[d*4 +: 4];
      e.an  = an_tab[d];
      e.seg = (blz && (d == 1 || d == 3) && nib == 4'd0) ? 7'h7F : pat(nib);
      e.dp  = ~dpv[d];
      e.err = err;
      q.push_back(e);
    end
  endtask

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: one check per newly presented digit slot.
  logic [3:0] prev_an = 4'hF;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_an = 4'hF;
    end else begin
      vectors++;
      if ($countones(~o_an) > 1) begin
        miscompares++;
        $display("FAIL onehot: an=%b", o_an);
      end
      if (o_an != prev_an) begin
        prev_an = o_an;
        if (o_an != 4'hF) begin
          vectors++;
          if (q.size() == 0) begin
            miscompares++;
            $display("FAIL slot: unexpected an=%b seg=%b", o_an, o_seg);
          end else begin
            e = q.pop_front();
            if (o_an !== e.an || o_seg !== e.seg ||
                o_dp !== e.dp || o_err !== e.err) begin
              miscompares++;
              $display("FAIL slot: got an=%b seg=%b dp=%b err=%b expected an=%b seg=%b dp=%b err=%b",
                       o_an, o_seg, o_dp, o_err, e.an, e.seg, e.dp, e.err);
            end
          end
        end
      end
    end
  end

  task automatic wait_an(input logic [3:0] target);
    logic seen_other;
    logic hit;
    seen_other = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      if (o_an != target) seen_other = 1'b1;
      else if (seen_other) hit = 1'b1;
    end
    if (!hit) begin
      miscompares++;
      $display("FAIL wait_an: an=%b never reached %b", o_an, target);
    end
  endtask

  task automatic pulse_load(input logic [15:0] w, input logic [3:0] dpv);
    bcd_in    = w;
    dp_in     = dpv;
    bcd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bcd_valid = 1'b0;
  endtask

  task automatic mid_load(input logic [15:0] w, input logic [3:0] dpv);
    repeat (5) @(posedge clk);
    @(negedge clk);
    pulse_load(w, dpv);
  endtask

  task automatic boundary_load(input logic [15:0] w, input logic [3:0] dpv);
    repeat (2) @(posedge clk);
    @(negedge clk);
    pulse_load(w, dpv);
  endtask

  task automatic chk_off(input string tag);
    chk({tag, "_an"},  16'(o_an),  16'h000F);
    chk({tag, "_seg"}, 16'(o_seg), 16'h007F);
    chk({tag, "_dp"},  16'(o_dp),  16'h0001);
    chk({tag, "_err"}, 16'(o_err), 16'h0000);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    bcd_in      = '0;
    bcd_valid   = 1'b0;
    blank_lz    = 1'b0;
    dp_in       = '0;
    repeat (3) @(negedge clk);
    chk_off("reset");
    push_frame(16'h0000, 4'h0, 1'b0, 1'b0);
    rst_n = 1'b1;

    wait_an(4'b0111);
    blank_lz = 1'b1;
    push_frame(16'h0000, 4'h0, 1'b1, 1'b0);
    mid_load(16'h0512, 4'h0);

    wait_an(4'b0111);
    push_frame(16'h0512, 4'h0, 1'b1, 1'b0);

    wait_an(4'b0111);
    blank_lz = 1'b0;
    push_frame(16'h0512, 4'h0, 1'b0, 1'b0);
    mid_load(16'h3A07, 4'b0101);

    wait_an(4'b0111);
    push_frame(16'h3A07, 4'b0101, 1'b0, 1'b1);
    mid_load(16'h1234, 4'b1000);

    wait_an(4'b0111);
    push_frame(16'h1234, 4'b1000, 1'b0, 1'b0);

    wait_an(4'b0111);
    push_frame(16'h8888, 4'b1111, 1'b0, 1'b0);
    boundary_load(16'h8888, 4'b1111);

    wait_an(4'b0111);
    push_frame(16'h8888, 4'b1111, 1'b0, 1'b0);
    mid_load(16'h1111, 4'b0000);
    pulse_load(16'h2222, 4'b0010);

    wait_an(4'b0111);
    push_frame(16'h2222, 4'b0010, 1'b0, 1'b0);

    wait_an(4'b0111);
    push_frame(16'h2222, 4'b0010, 1'b0, 1'b0);
    mid_load(16'h9999, 4'b1111);

    wait_an(4'b1011);
    #1 rst_n = 1'b0;
    #1 chk_off("async_rst");
    q.delete();
    repeat (3) @(negedge clk);
    push_frame(16'h0000, 4'h0, 1'b0, 1'b0);
    push_frame(16'h0000, 4'h0, 1'b0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d slots never presented", q.size());
    end
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
